// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and operand-sign decode helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, opnd}: LSB-first shift-add for multiply,
// MSB-first restoring shift-subtract for divide (opnd collects quotient bits).
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] mcand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] opnd_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum     = {1'b0, acc} + (opnd[0] ? {1'b0, mcand} : '0);
    shifted = {acc, opnd[XLEN-1]};
    fits    = shifted >= {1'b0, mcand};
    // Only consumed when fits, so the result is below 2^XLEN and the top bit can be dropped.
    diff    = shifted[XLEN-1:0] - mcand;
    if (div) begin
      acc_next  = fits ? diff : shifted[XLEN-1:0];
      opnd_next = {opnd[XLEN-2:0], fits};
    end else begin
      acc_next  = sum[XLEN:1];
      opnd_next = {sum[0], opnd[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide controller: sign handling and special cases
// at accept, XLEN unsigned iterations in BUSY, sign fix-up on the final edge.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   acc, opnd, mcand;
  logic [XLEN-1:0]   acc_next, opnd_next;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              sa, sb, div_zero, ovf, special, accept, last, neg_acc;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res, dval;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    sa          = is_signed_a(funct3_i) & rs1_i[XLEN-1];
    sb          = is_signed_b(funct3_i) & rs2_i[XLEN-1];
    mag_a       = sa ? -rs1_i : rs1_i;
    mag_b       = sb ? -rs2_i : rs2_i;
    div_zero    = is_div(funct3_i) && (rs2_i == '0);
    ovf         = is_div(funct3_i) && !funct3_i[0] &&
                  (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special     = div_zero || ovf;
    neg_acc     = is_rem(funct3_i) ? sa : (sa ^ sb);
    if (div_zero) special_res = is_rem(funct3_i) ? rs1_i : '1;
    else          special_res = is_rem(funct3_i) ? '0 : rs1_i;
    accept      = start_i && (state != ST_BUSY);
    last        = (state == ST_BUSY) && (cnt == CNT_W'(XLEN-1));
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div       (is_div(f3_q)),
    .acc       (acc),
    .opnd      (opnd),
    .mcand     (mcand),
    .acc_next  (acc_next),
    .opnd_next (opnd_next)
  );

  // The final result is taken from the step outputs so it lands on the last BUSY edge.
  always_comb begin
    prod   = {acc_next, opnd_next};
    prod_s = neg_q ? -prod : prod;
    dval   = is_rem(f3_q) ? acc_next : opnd_next;
    if (is_div(f3_q))         final_res = neg_q ? -dval : dval;
    else if (f3_q == MD_MUL)  final_res = prod_s[XLEN-1:0];
    else                      final_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) state_next = special ? ST_DONE : ST_BUSY;
        else         state_next = ST_IDLE;
      end
      ST_BUSY: if (last) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == ST_BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      mcand    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_next == ST_DONE);
      if (accept) begin
        f3_q  <= funct3_i;
        neg_q <= neg_acc;
        acc   <= '0;
        opnd  <= mag_a;
        mcand <= mag_b;
        cnt   <= '0;
        if (special) result_q <= special_res;
      end else if (state == ST_BUSY) begin
        acc  <= acc_next;
        opnd <= opnd_next;
        cnt  <= cnt + 1'b1;
        if (last) result_q <= final_res;
      end
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
